obi_data_initiator: RTL and testbench
=====================================

Name: obi_data_initiator

Overview:
- Command-driven OBI data-port initiator that drives the same req/gnt/rvalid memory interface the core's LSU uses.
- Lets test subsystems inject loads and stores into mm_ram independently of the core, for stimulus, pre-loading and memory checks.
- Accepts commands on a valid/ready port and issues them as in-order OBI transactions with bounded outstanding requests.
- Returns one registered response per completed transaction.

Parameters:
- MAX_OUTSTANDING, 2, maximum granted-but-not-responded transactions (1..8).
- ADDR_WIDTH, 32, width of cmd_addr_i / data_addr_o.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- cmd_valid_i  in  1  command present.
- cmd_ready_o  out  1  command accepted this cycle when high together with cmd_valid_i.
- cmd_we_i  in  1  1 = store, 0 = load.
- cmd_addr_i  in  ADDR_WIDTH  byte address.
- cmd_be_i  in  4  byte enables.
- cmd_wdata_i  in  32  store data.
- data_req_o  out  1  OBI request.
- data_gnt_i  in  1  OBI grant.
- data_addr_o  out  ADDR_WIDTH  OBI address.
- data_we_o  out  1  OBI write enable.
- data_be_o  out  4  OBI byte enables.
- data_wdata_o  out  32  OBI write data.
- data_atop_o  out  6  atomic op, constant 0.
- data_rvalid_i  in  1  OBI response valid.
- data_rdata_i  in  32  OBI read data.
- rsp_valid_o  out  1  one-cycle response pulse.
- rsp_we_o  out  1  response belongs to a store.
- rsp_rdata_o  out  32  load data; 0 for stores.
- idle_o  out  1  no pending request and nothing outstanding.
- err_unexpected_o  out  1  sticky: rvalid seen with nothing outstanding.

Behaviour:
- Reset (async, rst_ni=0):
  - State IDLE, outstanding count 0, tag FIFO empty.
  - All outputs 0 except idle_o=1.
  - Reset mid-transaction drops pending and outstanding transactions and emits no responses for them.
- FSM states: IDLE, REQ.
  - data_req_o = (state==REQ).
  - data_addr_o, data_we_o, data_be_o and data_wdata_o come from a command register. They are 0 in IDLE.
- cmd_ready_o = (state==IDLE || data_gnt_i) && (outstanding + (data_gnt_i && state==REQ)) < MAX_OUTSTANDING.
  - A response arriving in the same cycle is not credited, so the capacity check is conservative.
  - cmd_ready_o is combinational and independent of cmd_valid_i.
- IDLE -> REQ on acceptance: the command register loads, and data_req_o rises the next cycle.
- In REQ with data_gnt_i=0:
  - Hold data_req_o and every address/attribute/data field stable.
  - Never deassert data_req_o before grant.
- In REQ with data_gnt_i=1:
  - Push data_we_o into the tag FIFO.
  - If a new command is accepted in the same cycle, load it and stay in REQ (back-to-back, one request per cycle).
  - Otherwise go to IDLE.
- Outstanding counter: +1 on grant, -1 on data_rvalid_i. Simultaneous grant and rvalid leave it unchanged. It never exceeds MAX_OUTSTANDING.
- Response path (data_rvalid_i with outstanding>0), registered, latency 1 cycle after rvalid:
  - rsp_valid_o=1 for one cycle.
  - rsp_we_o = tag FIFO head, which is popped.
  - rsp_rdata_o = data_rdata_i for loads, 0 for stores.
  - Responses are in grant order.
  - A grant and an rvalid in the same cycle are allowed, including on the same transaction-free FIFO slot. The pop reads the old head before the push is written.
- Unexpected response: data_rvalid_i with outstanding==0 sets err_unexpected_o.
  - It stays set until reset.
  - No rsp_valid_o is produced and the counter does not change.
- Grant asserted while data_req_o=0 is ignored.
- idle_o = (state==IDLE) && (outstanding==0), registered equivalent acceptable only if it is exact in the same cycle. It is combinational from the state.
- Responder zero-wait case: mm_ram grants in the same cycle as req. In that case throughput is one transaction per cycle when the cap is not reached.

Test Plan:
- Single store: cmd we=1, addr=0x100, be=0xF, wdata=0xDEADBEEF with gnt tied 1 -> data_req_o high for exactly 1 cycle with those fields; on rvalid, rsp_valid_o pulses with rsp_we_o=1 and rsp_rdata_o=0.
- Load after store: read 0x100 through mm_ram -> rsp_valid_o with rsp_we_o=0 and rsp_rdata_o=0xDEADBEEF; idle_o returns to 1.
- Grant stall: hold gnt=0 for 5 cycles -> data_req_o and all fields stable throughout and cmd_ready_o=0; gnt=1 then completes the transaction.
- Outstanding limit (MAX_OUTSTANDING=2): 4 back-to-back commands with rvalid withheld -> exactly 2 grants, cmd_ready_o=0; each rvalid frees one slot; 4 responses return in order with correct rsp_we_o tags.
- Unexpected rvalid while idle -> err_unexpected_o=1 and stays set, rsp_valid_o stays 0; the next valid transaction still completes normally.
- Reset asserted with 1 granted and 1 pending request -> all outputs 0 immediately and idle_o=1; no rsp_valid_o after release.

Source files
------------

// File: rtl/obi_data_initiator.sv
// Command-driven OBI data-port initiator: turns valid/ready commands into in-order
// req/gnt/rvalid transactions with a bounded number outstanding and one response each.
module obi_data_initiator #(
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter int unsigned ADDR_WIDTH      = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic                  cmd_we_i,
    input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
    input  logic [3:0]            cmd_be_i,
    input  logic [31:0]           cmd_wdata_i,
    output logic                  data_req_o,
    input  logic                  data_gnt_i,
    output logic [ADDR_WIDTH-1:0] data_addr_o,
    output logic                  data_we_o,
    output logic [3:0]            data_be_o,
    output logic [31:0]           data_wdata_o,
    output logic [5:0]            data_atop_o,
    input  logic                  data_rvalid_i,
    input  logic [31:0]           data_rdata_i,
    output logic                  rsp_valid_o,
    output logic                  rsp_we_o,
    output logic [31:0]           rsp_rdata_o,
    output logic                  idle_o,
    output logic                  err_unexpected_o
);

    localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    typedef enum logic {IDLE, REQ} state_t;

    state_t                     r_state;
    logic [CW-1:0]              r_cnt;
    logic [PW-1:0]              r_wptr;
    logic [PW-1:0]              r_rptr;
    logic [MAX_OUTSTANDING-1:0] r_tag;
    logic [ADDR_WIDTH-1:0]      r_addr;
    logic                       r_we;
    logic [3:0]                 r_be;
    logic [31:0]                r_wdata;
    logic                       r_rsp_valid;
    logic                       r_rsp_we;
    logic [31:0]                r_rsp_rdata;
    logic                       r_err;

    logic                       w_grant;
    logic [CW:0]                w_cap;
    logic                       w_ready;
    logic                       w_accept;
    logic                       w_rsp;
    logic                       w_head;

    function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
        if (p == PW'(MAX_OUTSTANDING - 1)) return '0;
        return p + 1'b1;
    endfunction

    // Capacity check credits a grant happening now but never a same-cycle response.
    assign w_grant  = (r_state == REQ) && data_gnt_i;
    assign w_cap    = {1'b0, r_cnt} + {{CW{1'b0}}, w_grant};
    assign w_ready  = rst_ni && ((r_state == IDLE) || data_gnt_i) &&
                      (w_cap < (CW+1)'(MAX_OUTSTANDING));
    assign w_accept = cmd_valid_i && w_ready;
    assign w_rsp    = data_rvalid_i && (r_cnt != '0);
    assign w_head   = r_tag[r_rptr];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_tag       <= '0;
            r_addr      <= '0;
            r_we        <= 1'b0;
            r_be        <= '0;
            r_wdata     <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_we    <= 1'b0;
            r_rsp_rdata <= '0;
            r_err       <= 1'b0;
        end else begin
            if (w_accept) begin
                r_state <= REQ;
                r_addr  <= cmd_addr_i;
                r_we    <= cmd_we_i;
                r_be    <= cmd_be_i;
                r_wdata <= cmd_wdata_i;
            end else if (w_grant) begin
                r_state <= IDLE;
                r_addr  <= '0;
                r_we    <= 1'b0;
                r_be    <= '0;
                r_wdata <= '0;
            end

            // Pop reads the old head; push targets a different slot since never full here.
            if (w_grant) begin
                r_tag[r_wptr] <= r_we;
                r_wptr        <= f_inc(r_wptr);
            end
            if (w_rsp) r_rptr <= f_inc(r_rptr);

            case ({w_grant, w_rsp})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase

            r_rsp_valid <= w_rsp;
            r_rsp_we    <= w_rsp && w_head;
            r_rsp_rdata <= (w_rsp && !w_head) ? data_rdata_i : '0;

            if (data_rvalid_i && (r_cnt == '0)) r_err <= 1'b1;
        end
    end

    assign cmd_ready_o      = w_ready;
    assign data_req_o       = (r_state == REQ);
    assign data_addr_o      = r_addr;
    assign data_we_o        = r_we;
    assign data_be_o        = r_be;
    assign data_wdata_o     = r_wdata;
    assign data_atop_o      = '0;
    assign rsp_valid_o      = r_rsp_valid;
    assign rsp_we_o         = r_rsp_we;
    assign rsp_rdata_o      = r_rsp_rdata;
    assign idle_o           = (r_state == IDLE) && (r_cnt == '0);
    assign err_unexpected_o = r_err;

endmodule

// File: tb/tb_obi_data_initiator.sv
// Vector-table bench for obi_data_initiator (MAX_OUTSTANDING=2) plus a mid-transaction reset sequence.
module tb_obi_data_initiator;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_we;
    logic [31:0] cmd_addr;
    logic [3:0]  cmd_be;
    logic [31:0] cmd_wdata;
    logic        data_req;
    logic        data_gnt;
    logic [31:0] data_addr;
    logic        data_we;
    logic [3:0]  data_be;
    logic [31:0] data_wdata;
    logic [5:0]  data_atop;
    logic        data_rvalid;
    logic [31:0] data_rdata;
    logic        rsp_valid;
    logic        rsp_we;
    logic [31:0] rsp_rdata;
    logic        idle;
    logic        err_unexp;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    obi_data_initiator #(.MAX_OUTSTANDING(2), .ADDR_WIDTH(32)) dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .cmd_valid_i      (cmd_valid),
        .cmd_ready_o      (cmd_ready),
        .cmd_we_i         (cmd_we),
        .cmd_addr_i       (cmd_addr),
        .cmd_be_i         (cmd_be),
        .cmd_wdata_i      (cmd_wdata),
        .data_req_o       (data_req),
        .data_gnt_i       (data_gnt),
        .data_addr_o      (data_addr),
        .data_we_o        (data_we),
        .data_be_o        (data_be),
        .data_wdata_o     (data_wdata),
        .data_atop_o      (data_atop),
        .data_rvalid_i    (data_rvalid),
        .data_rdata_i     (data_rdata),
        .rsp_valid_o      (rsp_valid),
        .rsp_we_o         (rsp_we),
        .rsp_rdata_o      (rsp_rdata),
        .idle_o           (idle),
        .err_unexpected_o (err_unexp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic v, we; logic [31:0] a; logic [3:0] be; logic [31:0] wd;
        logic g, rv; logic [31:0] rd;
        logic erdy, ereq; logic [31:0] ea; logic ewe; logic [3:0] ebe; logic [31:0] ewd;
        logic ersv, erswe; logic [31:0] ersd; logic eidle, eerr;
    } vec_t;

    function automatic vec_t mk(
        input logic v, we, input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd,
        input logic g, rv, input logic [31:0] rd,
        input logic erdy, ereq, input logic [31:0] ea, input logic ewe, input logic [3:0] ebe,
        input logic [31:0] ewd, input logic ersv, erswe, input logic [31:0] ersd,
        input logic eidle, eerr);
        vec_t t;
        t.v = v; t.we = we; t.a = a; t.be = be; t.wd = wd; t.g = g; t.rv = rv; t.rd = rd;
        t.erdy = erdy; t.ereq = ereq; t.ea = ea; t.ewe = ewe; t.ebe = ebe; t.ewd = ewd;
        t.ersv = ersv; t.erswe = erswe; t.ersd = ersd; t.eidle = eidle; t.eerr = eerr;
        return t;
    endfunction

    // {ready, req, addr, we, be, wdata, atop, rsp_valid, rsp_we, rsp_rdata, idle, err}
    function automatic logic [127:0] obs();
        return {15'd0, cmd_ready, data_req, data_addr, data_we, data_be, data_wdata, data_atop,
                rsp_valid, rsp_we, rsp_rdata, idle, err_unexp};
    endfunction

    function automatic logic [127:0] expv(input vec_t t);
        return {15'd0, t.erdy, t.ereq, t.ea, t.ewe, t.ebe, t.ewd, 6'd0,
                t.ersv, t.erswe, t.ersd, t.eidle, t.eerr};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t t);
        cmd_valid = t.v; cmd_we = t.we; cmd_addr = t.a; cmd_be = t.be; cmd_wdata = t.wd;
        data_gnt = t.g; data_rvalid = t.rv; data_rdata = t.rd;
    endtask

    vec_t tv[$];
    vec_t z;

    initial begin
        z = mk(0,0,0,0,0, 0,0,0, 0,0,0,0,0,0, 0,0,0, 0,0);
        // single store, gnt tied high
        tv.push_back(mk(1,1,'h100,'hF,'hDEADBEEF, 1,0,0,          1,0,0,0,0,0,                 0,0,0, 1,0));
        tv.push_back(mk(0,0,0,0,0,               1,0,0,          1,1,'h100,1,'hF,'hDEADBEEF,  0,0,0, 0,0));
        tv.push_back(mk(0,0,0,0,0,               1,0,0,          1,0,0,0,0,0,                 0,0,0, 0,0));
        tv.push_back(mk(0,0,0,0,0,               1,1,'h12345678, 1,0,0,0,0,0,                 0,0,0, 0,0));
        tv.push_back(mk(0,0,0,0,0,               1,0,0,          1,0,0,0,0,0,                 1,1,0, 1,0));
        // load of the stored word
        tv.push_back(mk(1,0,'h100,'hF,0,         1,0,0,          1,0,0,0,0,0,                 0,0,0, 1,0));
        tv.push_back(mk(0,0,0,0,0,               1,0,0,          1,1,'h100,0,'hF,0,           0,0,0, 0,0));
        tv.push_back(mk(0,0,0,0,0,               1,1,'hDEADBEEF, 1,0,0,0,0,0,                 0,0,0, 0,0));
        tv.push_back(mk(0,0,0,0,0,               1,0,0,          1,0,0,0,0,0,                 1,0,'hDEADBEEF, 1,0));
        // grant stall for 5 cycles
        tv.push_back(mk(1,1,'h200,'h3,'hA5A50001, 0,0,0,         1,0,0,0,0,0,                 0,0,0, 1,0));
        for (int i = 0; i < 5; i++)
            tv.push_back(mk(1,0,'h300,'hF,0,     0,0,0,          0,1,'h200,1,'h3,'hA5A50001,  0,0,0, 0,0));
        tv.push_back(mk(0,0,0,0,0,               1,0,0,          1,1,'h200,1,'h3,'hA5A50001,  0,0,0, 0,0));
        tv.push_back(mk(0,0,0,0,0,               0,1,'hFFFFFFFF, 1,0,0,0,0,0,                 0,0,0, 0,0));
        tv.push_back(mk(0,0,0,0,0,               0,0,0,          1,0,0,0,0,0,                 1,1,0, 1,0));
        // outstanding cap: A(st) B(ld) C(st) D(ld)
        tv.push_back(mk(1,1,'h400,'hF,'h11111111, 1,0,0,         1,0,0,0,0,0,                 0,0,0, 1,0));
        tv.push_back(mk(1,0,'h404,'hF,0,         1,0,0,          1,1,'h400,1,'hF,'h11111111,  0,0,0, 0,0));
        tv.push_back(mk(1,1,'h408,'hF,'h33333333, 1,0,0,         0,1,'h404,0,'hF,0,           0,0,0, 0,0));
        tv.push_back(mk(1,1,'h408,'hF,'h33333333, 1,0,0,         0,0,0,0,0,0,                 0,0,0, 0,0));
        tv.push_back(mk(1,1,'h408,'hF,'h33333333, 1,1,'hAAAA0000, 0,0,0,0,0,0,                0,0,0, 0,0));
        tv.push_back(mk(1,1,'h408,'hF,'h33333333, 1,0,0,         1,0,0,0,0,0,                 1,1,0, 0,0));
        tv.push_back(mk(1,0,'h40C,'hF,0,         1,1,'hBBBB0004, 0,1,'h408,1,'hF,'h33333333,  0,0,0, 0,0));
        tv.push_back(mk(1,0,'h40C,'hF,0,         1,0,0,          1,0,0,0,0,0,                 1,0,'hBBBB0004, 0,0));
        tv.push_back(mk(0,0,0,0,0,               1,0,0,          0,1,'h40C,0,'hF,0,           0,0,0, 0,0));
        tv.push_back(mk(0,0,0,0,0,               1,1,'hCCCC0008, 0,0,0,0,0,0,                 0,0,0, 0,0));
        tv.push_back(mk(0,0,0,0,0,               0,1,'hDDDD000C, 1,0,0,0,0,0,                 1,1,0, 0,0));
        tv.push_back(mk(0,0,0,0,0,               0,0,0,          1,0,0,0,0,0,                 1,0,'hDDDD000C, 1,0));
        // unexpected rvalid while idle, then a normal store
        tv.push_back(mk(0,0,0,0,0,               0,1,'h5555,     1,0,0,0,0,0,                 0,0,0, 1,0));
        tv.push_back(mk(0,0,0,0,0,               0,0,0,          1,0,0,0,0,0,                 0,0,0, 1,1));
        tv.push_back(mk(1,1,'h500,'hC,'hCAFEF00D, 1,0,0,         1,0,0,0,0,0,                 0,0,0, 1,1));
        tv.push_back(mk(0,0,0,0,0,               1,0,0,          1,1,'h500,1,'hC,'hCAFEF00D,  0,0,0, 0,1));
        tv.push_back(mk(0,0,0,0,0,               0,1,0,          1,0,0,0,0,0,                 0,0,0, 0,1));
        tv.push_back(mk(0,0,0,0,0,               0,0,0,          1,0,0,0,0,0,                 1,1,0, 1,1));

        // reset state, with a command offered during reset
        rst_n = 1'b0;
        drive(mk(1,1,'h10,'hF,'h1, 1,0,0, 0,0,0,0,0,0, 0,0,0, 0,0));
        repeat (2) @(negedge clk);
        #1 check("reset_state", obs(), expv(mk(0,0,0,0,0, 0,0,0, 0,0,0,0,0,0, 0,0,0, 1,0)));
        drive(z);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tv[i]) begin
            @(negedge clk);
            drive(tv[i]);
            #1 check($sformatf("vec%0d", i), obs(), expv(tv[i]));
        end

        // reset with one granted and one pending request
        @(negedge clk);
        drive(mk(1,1,'h600,'hF,'h66666666, 1,0,0, 0,0,0,0,0,0, 0,0,0, 0,0));
        #1 check("mid_accept_x", {127'd0, cmd_ready}, 128'd1);
        @(negedge clk);
        drive(mk(1,0,'h604,'hF,0, 1,0,0, 0,0,0,0,0,0, 0,0,0, 0,0));
        #1 check("mid_grant_x", {95'd0, cmd_ready, data_req, data_addr}, {95'd0, 1'b1, 1'b1, 32'h600});
        @(negedge clk);
        drive(z);
        #1 check("mid_pending_y", {94'd0, cmd_ready, data_req, idle, data_addr},
                 {94'd0, 1'b0, 1'b1, 1'b0, 32'h604});
        #1 rst_n = 1'b0;
        #1 check("mid_reset", obs(), expv(mk(0,0,0,0,0, 0,0,0, 0,0,0,0,0,0, 0,0,0, 1,0)));
        @(negedge clk);
        rst_n = 1'b1;
        data_rvalid = 1'b1;
        data_rdata  = 32'h77;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            data_rvalid = 1'b0;
            #1 check($sformatf("post_reset_rsp%0d", i), {126'd0, rsp_valid, idle}, {126'd0, 1'b0, 1'b1});
        end
        check("post_reset_err", {127'd0, err_unexp}, 128'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
